// File: rtl/uarc_rx_arbiter_if.sv
// uarc_rx_arbiter_if: receiver bus pins plus core-side rx/kill signals.
// slave = arbiter side, master = bus/core environment side.
interface uarc_rx_arbiter_if #(
    parameter int WORD_MAG    = 5,
    parameter int TOTAL_BUSES = 4
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;
    localparam int IDX_WIDTH  =
        $clog2(TOTAL_BUSES > 2 ? TOTAL_BUSES : 2);

    logic [TOTAL_BUSES-1:0]                 receiver_enables;
    logic [TOTAL_BUSES-1:0]                 receiver_kills;
    logic [TOTAL_BUSES-1:0]                 receiver_kill_acks;
    logic [TOTAL_BUSES-1:0]                 receiver_sends;
    logic [TOTAL_BUSES-1:0]                 receiver_send_acks;
    logic [TOTAL_BUSES-1:0]                 receiver_streams;
    logic [TOTAL_BUSES-1:0]                 receiver_stream_acks;
    logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0] receiver_datas;
    logic                                   rx_valid;
    logic                                   rx_ready;
    logic [WORD_WIDTH-1:0]                  rx_data;
    logic [IDX_WIDTH-1:0]                   rx_bus;
    logic                                   rx_stream;
    logic                                   kill_pending;
    logic [IDX_WIDTH-1:0]                   kill_bus;
    logic                                   kill_clear;

    modport slave (
        input  receiver_enables,
        input  receiver_kills,
        output receiver_kill_acks,
        input  receiver_sends,
        output receiver_send_acks,
        input  receiver_streams,
        output receiver_stream_acks,
        input  receiver_datas,
        output rx_valid,
        input  rx_ready,
        output rx_data,
        output rx_bus,
        output rx_stream,
        output kill_pending,
        output kill_bus,
        input  kill_clear
    );

    modport master (
        output receiver_enables,
        output receiver_kills,
        input  receiver_kill_acks,
        output receiver_sends,
        input  receiver_send_acks,
        output receiver_streams,
        input  receiver_stream_acks,
        output receiver_datas,
        input  rx_valid,
        output rx_ready,
        input  rx_data,
        input  rx_bus,
        input  rx_stream,
        input  kill_pending,
        input  kill_bus,
        output kill_clear
    );
endinterface

// File: rtl/uarc_rx_arbiter.sv
// uarc_rx_arbiter: kill-priority, round-robin send/stream arbiter
// feeding a small circular FIFO, with registered one-cycle acks.
module uarc_rx_arbiter #(
    parameter int WORD_MAG    = 5,
    parameter int TOTAL_BUSES = 4,
    parameter int FIFO_MAG    = 2
) (
    input logic              clk,
    input logic              reset,
    uarc_rx_arbiter_if.slave rx_if
);
    localparam int WORD_WIDTH = 1 << WORD_MAG;
    localparam int DEPTH      = 1 << FIFO_MAG;
    localparam int IDX_WIDTH  =
        $clog2(TOTAL_BUSES > 2 ? TOTAL_BUSES : 2);

    localparam logic [FIFO_MAG:0]   CNT_ONE = 1;
    localparam logic [FIFO_MAG-1:0] PTR_ONE = 1;

    logic [TOTAL_BUSES-1:0] kill_ack_q, kill_ack_d;
    logic [TOTAL_BUSES-1:0] send_ack_q, send_ack_d;
    logic [TOTAL_BUSES-1:0] stream_ack_q, stream_ack_d;
    logic                   kill_pending_q, kill_pending_d;
    logic [IDX_WIDTH-1:0]   kill_bus_q, kill_bus_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [FIFO_MAG-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FIFO_MAG-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FIFO_MAG:0]      count_q, count_d;

    logic [WORD_WIDTH-1:0]  data_mem_q [DEPTH];
    logic [IDX_WIDTH-1:0]   bus_mem_q  [DEPTH];
    logic                   strm_mem_q [DEPTH];

    logic [TOTAL_BUSES-1:0] eligible;
    logic [TOTAL_BUSES-1:0] kill_req;
    logic [TOTAL_BUSES-1:0] req;
    logic                   kill_found;
    logic [IDX_WIDTH-1:0]   kill_idx;
    logic                   grant_found;
    logic [IDX_WIDTH-1:0]   grant_idx;
    logic                   grant_send;
    logic [WORD_WIDTH-1:0]  grant_data;
    logic                   kill_take;
    logic                   pop;
    logic                   push;
    logic                   rx_valid;

    assign rx_valid = |count_q;

    // Pick the lowest eligible kill and the round-robin send/stream winner.
    always_comb begin
        int j;
        j           = 0;
        eligible    = rx_if.receiver_enables
                    & ~(kill_ack_q | send_ack_q | stream_ack_q);
        kill_req    = eligible & rx_if.receiver_kills;
        req         = eligible
                    & (rx_if.receiver_sends | rx_if.receiver_streams);
        kill_found  = 1'b0;
        kill_idx    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_send  = 1'b0;
        grant_data  = '0;
        for (int i = TOTAL_BUSES - 1; i >= 0; i--) begin
            if (kill_req[i]) begin
                kill_found = 1'b1;
                kill_idx   = IDX_WIDTH'(i);
            end
        end
        for (int k = 0; k < TOTAL_BUSES; k++) begin
            j = (int'(rr_ptr_q) + k) % TOTAL_BUSES;
            if (!grant_found && req[j]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_WIDTH'(j);
                grant_send  = rx_if.receiver_sends[j];
                grant_data  = rx_if.receiver_datas[j];
            end
        end
    end

    // Next-state: kill flag, acks, round-robin pointer and FIFO bookkeeping.
    always_comb begin
        kill_take      = kill_found
                       && (!kill_pending_q || rx_if.kill_clear);
        pop            = rx_valid && rx_if.rx_ready;
        push           = !kill_take && grant_found
                       && (!count_q[FIFO_MAG] || pop);
        kill_ack_d     = '0;
        send_ack_d     = '0;
        stream_ack_d   = '0;
        kill_pending_d = kill_pending_q;
        kill_bus_d     = kill_bus_q;
        rr_ptr_d       = rr_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        if (kill_take) begin
            kill_ack_d[kill_idx] = 1'b1;
            kill_pending_d       = 1'b1;
            kill_bus_d           = kill_idx;
            wr_ptr_d             = '0;
            rd_ptr_d             = '0;
            count_d              = '0;
        end else begin
            if (rx_if.kill_clear) begin
                kill_pending_d = 1'b0;
            end
            if (push) begin
                send_ack_d[grant_idx]   = grant_send;
                stream_ack_d[grant_idx] = !grant_send;
                rr_ptr_d = IDX_WIDTH'(
                    (int'(grant_idx) + 1) % TOTAL_BUSES);
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + CNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kill_ack_q     <= '0;
            send_ack_q     <= '0;
            stream_ack_q   <= '0;
            kill_pending_q <= 1'b0;
            kill_bus_q     <= '0;
            rr_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            kill_ack_q     <= kill_ack_d;
            send_ack_q     <= send_ack_d;
            stream_ack_q   <= stream_ack_d;
            kill_pending_q <= kill_pending_d;
            kill_bus_q     <= kill_bus_d;
            rr_ptr_q       <= rr_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= grant_data;
            bus_mem_q[wr_ptr_q]  <= grant_idx;
            strm_mem_q[wr_ptr_q] <= !grant_send;
        end
    end

    assign rx_if.receiver_kill_acks   = kill_ack_q;
    assign rx_if.receiver_send_acks   = send_ack_q;
    assign rx_if.receiver_stream_acks = stream_ack_q;
    assign rx_if.rx_valid             = rx_valid;
    assign rx_if.rx_data              = data_mem_q[rd_ptr_q];
    assign rx_if.rx_bus               = bus_mem_q[rd_ptr_q];
    assign rx_if.rx_stream            = strm_mem_q[rd_ptr_q];
    assign rx_if.kill_pending         = kill_pending_q;
    assign rx_if.kill_bus             = kill_bus_q;
endmodule

// File: tb/tb_uarc_rx_arbiter.sv
// tb_uarc_rx_arbiter: vector table, directed sequences and a
// randomized run against a queue-based reference model.
module tb_uarc_rx_arbiter;
    localparam int NB = 4;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    uarc_rx_arbiter_if #(.WORD_MAG(5), .TOTAL_BUSES(NB)) bus ();

    uarc_rx_arbiter #(
        .WORD_MAG(5), .TOTAL_BUSES(NB), .FIFO_MAG(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_if(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] kill;
        logic [3:0] send;
        logic [3:0] strm;
        logic [3:0] kack;
        logic [3:0] sack;
        logic [3:0] tack;
        logic       valid;
        logic [1:0] rbus;
        logic       rstrm;
        logic       kp;
        logic [1:0] kbus;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          src;
        bit          strm;
    } ent_t;

    vec_t vecs [10];

    ent_t       mq [$];
    logic [3:0] mk, ms, mt;
    bit         mkp;
    int         mkb;
    int         mrr;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.receiver_enables = 4'hF;
        bus.receiver_kills   = '0;
        bus.receiver_sends   = '0;
        bus.receiver_streams = '0;
        bus.rx_ready         = 1'b0;
        bus.kill_clear       = 1'b0;
        for (int i = 0; i < NB; i++)
            bus.receiver_datas[i] = 32'hA5A5_0000 | 32'(i);
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_acks(input string nm, input logic [3:0] k,
                            input logic [3:0] s, input logic [3:0] t);
        chk({nm, "_kack"}, 32'(bus.receiver_kill_acks), 32'(k));
        chk({nm, "_sack"}, 32'(bus.receiver_send_acks), 32'(s));
        chk({nm, "_tack"}, 32'(bus.receiver_stream_acks), 32'(t));
    endtask

    task automatic model_step();
        logic [3:0] elig, kreq, req;
        int   kidx, g, j;
        bit   pop;
        ent_t e;
        elig = bus.receiver_enables & ~(mk | ms | mt);
        kreq = elig & bus.receiver_kills;
        req  = elig & (bus.receiver_sends | bus.receiver_streams);
        mk = '0; ms = '0; mt = '0;
        kidx = -1;
        for (int i = 0; i < NB; i++)
            if (kreq[i] && kidx < 0) kidx = i;
        if (kidx >= 0 && (!mkp || bus.kill_clear)) begin
            mk[kidx] = 1'b1;
            mkp = 1'b1;
            mkb = kidx;
            mq.delete();
        end else begin
            if (bus.kill_clear) mkp = 1'b0;
            pop = (mq.size() > 0) && bus.rx_ready;
            g = -1;
            for (int k = 0; k < NB; k++) begin
                j = (mrr + k) % NB;
                if (g < 0 && req[j]) g = j;
            end
            if (pop) void'(mq.pop_front());
            if (g >= 0 && (mq.size() < 4)) begin
                e.data = bus.receiver_datas[g];
                e.src  = g;
                e.strm = !bus.receiver_sends[g];
                mq.push_back(e);
                if (e.strm) mt[g] = 1'b1;
                else        ms[g] = 1'b1;
                mrr = (g + 1) % NB;
            end
        end
    endtask

    initial begin
        int acks;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;

        vecs[0] = '{4'hF, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 4'h0,
                    1'b1, 2'd2, 1'b0, 1'b0, 2'd0};
        vecs[1] = '{4'hF, 4'h0, 4'hA, 4'h0, 4'h0, 4'h2, 4'h0,
                    1'b1, 2'd1, 1'b0, 1'b0, 2'd0};
        vecs[2] = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h8,
                    1'b1, 2'd3, 1'b1, 1'b0, 2'd0};
        vecs[3] = '{4'h7, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0,
                    1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[4] = '{4'hF, 4'h0, 4'h1, 4'h1, 4'h0, 4'h1, 4'h0,
                    1'b1, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[5] = '{4'hF, 4'hA, 4'hF, 4'h0, 4'h2, 4'h0, 4'h0,
                    1'b0, 2'd0, 1'b0, 1'b1, 2'd1};
        vecs[6] = '{4'hD, 4'h6, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0,
                    1'b0, 2'd0, 1'b0, 1'b1, 2'd2};
        vecs[7] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
                    1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0,
                    1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
        vecs[9] = '{4'hF, 4'h0, 4'h6, 4'h6, 4'h0, 4'h2, 4'h0,
                    1'b1, 2'd1, 1'b0, 1'b0, 2'd0};

        do_reset();
        chk_acks("rst", 4'h0, 4'h0, 4'h0);
        chk("rst_valid", 32'(bus.rx_valid), 32'd0);
        chk("rst_kp", 32'(bus.kill_pending), 32'd0);
        chk("rst_kbus", 32'(bus.kill_bus), 32'd0);

        for (int v = 0; v < 10; v++) begin
            do_reset();
            bus.receiver_enables = vecs[v].en;
            bus.receiver_kills   = vecs[v].kill;
            bus.receiver_sends   = vecs[v].send;
            bus.receiver_streams = vecs[v].strm;
            cyc();
            chk_acks($sformatf("vec%0d", v),
                     vecs[v].kack, vecs[v].sack, vecs[v].tack);
            chk("vec_valid", 32'(bus.rx_valid), 32'(vecs[v].valid));
            chk("vec_kp", 32'(bus.kill_pending), 32'(vecs[v].kp));
            chk("vec_kbus", 32'(bus.kill_bus), 32'(vecs[v].kbus));
            if (vecs[v].valid) begin
                chk("vec_bus", 32'(bus.rx_bus), 32'(vecs[v].rbus));
                chk("vec_strm", 32'(bus.rx_stream),
                    32'(vecs[v].rstrm));
                chk("vec_data", bus.rx_data,
                    32'hA5A5_0000 | 32'(vecs[v].rbus));
            end
        end

        // single send with DEADBEEF on bus 2
        do_reset();
        bus.receiver_datas[2] = 32'hDEAD_BEEF;
        bus.receiver_sends    = 4'h4;
        cyc();
        chk_acks("db1", 4'h0, 4'h4, 4'h0);
        chk("db_valid", 32'(bus.rx_valid), 32'd1);
        chk("db_data", bus.rx_data, 32'hDEAD_BEEF);
        chk("db_bus", 32'(bus.rx_bus), 32'd2);
        chk("db_strm", 32'(bus.rx_stream), 32'd0);
        bus.receiver_sends = 4'h0;
        cyc();
        chk_acks("db2", 4'h0, 4'h0, 4'h0);
        chk("db_valid2", 32'(bus.rx_valid), 32'd1);
        bus.rx_ready = 1'b1;
        cyc();
        chk("db_empty", 32'(bus.rx_valid), 32'd0);

        // reset mid-handshake drops the ack immediately
        do_reset();
        bus.receiver_sends = 4'h1;
        cyc();
        chk("mr_ack", 32'(bus.receiver_send_acks), 32'h1);
        reset = 1'b1;
        #1;
        chk("mr_ack0", 32'(bus.receiver_send_acks), 32'h0);
        chk("mr_valid0", 32'(bus.rx_valid), 32'd0);
        cyc();
        reset = 1'b0;

        // continuous sends on all buses with rx_ready high
        do_reset();
        bus.receiver_sends = 4'hF;
        bus.rx_ready       = 1'b1;
        for (int c = 0; c < 8; c++) begin
            cyc();
            chk("rr_sack", 32'(bus.receiver_send_acks),
                32'(1 << (c % 4)));
            chk("rr_bus", 32'(bus.rx_bus), 32'(c % 4));
            chk("rr_valid", 32'(bus.rx_valid), 32'd1);
        end

        // backpressure: FIFO fills to 4 then holds
        do_reset();
        bus.receiver_sends = 4'hF;
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk("bp_sack", 32'(bus.receiver_send_acks),
                c < 4 ? 32'(1 << c) : 32'd0);
            for (int i = 0; i < NB; i++)
                acks += int'(bus.receiver_send_acks[i]);
        end
        chk("bp_total", 32'(acks), 32'd4);
        chk("bp_head0", 32'(bus.rx_bus), 32'd0);
        bus.rx_ready = 1'b1;
        cyc();
        chk("bp_refill", 32'(bus.receiver_send_acks), 32'h1);
        chk("bp_head1", 32'(bus.rx_bus), 32'd1);
        bus.receiver_sends = 4'h0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("bp_order", 32'(bus.rx_bus), 32'((c + 2) % 4));
            chk("bp_ovalid", 32'(bus.rx_valid), 32'd1);
        end
        cyc();
        chk("bp_drained", 32'(bus.rx_valid), 32'd0);

        // kill with 3 queued entries and a concurrent send
        do_reset();
        bus.receiver_sends = 4'h2;
        cyc();
        bus.receiver_sends = 4'h4;
        cyc();
        bus.receiver_sends = 4'h8;
        cyc();
        chk("k_pre_valid", 32'(bus.rx_valid), 32'd1);
        bus.receiver_kills = 4'h2;
        bus.receiver_sends = 4'h1;
        cyc();
        chk_acks("k1", 4'h2, 4'h0, 4'h0);
        chk("k1_kp", 32'(bus.kill_pending), 32'd1);
        chk("k1_kbus", 32'(bus.kill_bus), 32'd1);
        chk("k1_valid", 32'(bus.rx_valid), 32'd0);
        bus.receiver_kills = 4'h8;
        cyc();
        chk_acks("k2", 4'h0, 4'h1, 4'h0);
        chk("k2_kbus", 32'(bus.kill_bus), 32'd1);
        chk("k2_head", 32'(bus.rx_bus), 32'd0);
        bus.receiver_sends = 4'h0;
        cyc();
        chk_acks("k3", 4'h0, 4'h0, 4'h0);
        chk("k3_kp", 32'(bus.kill_pending), 32'd1);
        bus.kill_clear = 1'b1;
        cyc();
        chk_acks("k4", 4'h8, 4'h0, 4'h0);
        chk("k4_kp", 32'(bus.kill_pending), 32'd1);
        chk("k4_kbus", 32'(bus.kill_bus), 32'd3);
        chk("k4_flush", 32'(bus.rx_valid), 32'd0);
        bus.receiver_kills = 4'h0;
        cyc();
        chk("k5_kp", 32'(bus.kill_pending), 32'd0);

        // disabled bus 3 and a bus with send+stream together
        do_reset();
        bus.receiver_enables = 4'h7;
        bus.receiver_sends   = 4'hA;
        bus.receiver_streams = 4'h2;
        cyc();
        chk_acks("ss1", 4'h0, 4'h2, 4'h0);
        bus.receiver_sends = 4'h8;
        cyc();
        chk_acks("ss2", 4'h0, 4'h0, 4'h0);
        cyc();
        chk_acks("ss3", 4'h0, 4'h0, 4'h2);
        bus.receiver_streams = 4'h0;
        chk("ss_h0", 32'(bus.rx_stream), 32'd0);
        bus.rx_ready = 1'b1;
        cyc();
        chk("ss_h1", 32'(bus.rx_stream), 32'd1);
        chk("ss_h1bus", 32'(bus.rx_bus), 32'd1);
        chk("ss_no3", 32'(bus.receiver_send_acks[3]), 32'd0);
        cyc();
        chk("ss_empty", 32'(bus.rx_valid), 32'd0);

        // randomized run against the reference model
        do_reset();
        mq.delete();
        mk = '0; ms = '0; mt = '0;
        mkp = 1'b0; mkb = 0; mrr = 0;
        for (int c = 0; c < 400; c++) begin
            bus.receiver_enables = ($urandom % 4 == 0) ?
                4'($urandom) : 4'hF;
            bus.receiver_kills = ($urandom % 10 == 0) ?
                4'(1 << $urandom_range(0, 3)) : 4'h0;
            bus.receiver_sends   = 4'($urandom);
            bus.receiver_streams = 4'($urandom);
            bus.rx_ready   = ($urandom % 3) != 0;
            bus.kill_clear = ($urandom % 4) == 0;
            for (int i = 0; i < NB; i++)
                bus.receiver_datas[i] = $urandom;
            model_step();
            cyc();
            chk_acks("rnd", mk, ms, mt);
            chk("rnd_valid", 32'(bus.rx_valid),
                32'(mq.size() > 0));
            chk("rnd_kp", 32'(bus.kill_pending), 32'(mkp));
            chk("rnd_kbus", 32'(bus.kill_bus), 32'(mkb));
            if (mq.size() > 0) begin
                chk("rnd_data", bus.rx_data, mq[0].data);
                chk("rnd_bus", 32'(bus.rx_bus), 32'(mq[0].src));
                chk("rnd_strm", 32'(bus.rx_stream),
                    32'(mq[0].strm));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
